// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the sequential ALU.
//   mode_e    - operation selected by the mode counter (ADD, SUB, MUL, MAC)
//   state_e   - top-level control FSM states (IDLE, CALC)
//   NUM_MODES - number of modes the mode counter cycles through
package alu_seq_pkg;

    localparam int NUM_MODES = 4;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        MAC = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand bus, controls and result/status signals of alu_seq.
//   master (driver side): in_data, ea, eb, mode_step, start, clr -> ALU
//   slave  (ALU side)   : mode, a_value, b_value, result, busy, done -> display
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int RES_W = 2 * WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             ea;
    logic             eb;
    logic             mode_step;
    logic             start;
    logic             clr;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a_value;
    logic [WIDTH-1:0] b_value;
    logic [RES_W-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output in_data, ea, eb, mode_step, start, clr,
        input  mode, a_value, b_value, result, busy, done
    );

    modport slave (
        input  in_data, ea, eb, mode_step, start, clr,
        output mode, a_value, b_value, result, busy, done
    );
endinterface

// File: rtl/alu_seq_mul.sv
// seq_mul: iterative unsigned shift-add multiplier, one bit of b per cycle.
//   clk, reset (async, active-low)
//   start   - load a/b and begin; ignored while busy
//   abort   - cancel a running multiply (no done)
//   a, b    - operands (WIDTH bits, unsigned)
//   busy    - registered, high for exactly WIDTH cycles after start
//   done    - combinational: this cycle's edge performs the final step
//   product - combinational value the accumulator takes on this edge;
//             equals a*b mod 2^RES_W while done is high
// Exposing the final step combinationally lets the caller write its
// result register on the same edge that busy falls.
module seq_mul #(
    parameter int WIDTH = 8,
    parameter int RES_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [RES_W-1:0] mcand;
    logic [RES_W-1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && !abort && (cnt == CNT_W'(1));

    // control: busy flag and iteration counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            if (abort) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1))
                    busy <= 1'b0;
            end
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(WIDTH);
        end
    end

    // datapath: shifted multiplicand, remaining multiplier bits, partial product
    always_ff @(posedge clk) begin
        if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (start) begin
            mcand  <= {{(RES_W - WIDTH){1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with ADD, SUB, MUL and MAC modes.
//   clk   - single clock, rising edge
//   reset - asynchronous, active-low; clears every output
//   bus   - alu_seq_if.slave: operand bus, load enables, mode step,
//           start/clr in; mode, operands, result, busy, done out
// ADD/SUB complete on the start edge; MUL/MAC run the iterative
// multiplier for WIDTH cycles and write result as busy falls.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RES_W = 2 * WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [RES_W-1:0] res_q;
    mode_e            mode_q;
    state_e           state;
    logic             done_q;
    logic             ms_q;
    logic             mac_q;

    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [RES_W-1:0] mul_prod;

    function automatic logic [RES_W-1:0] add_zext(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        return {{(RES_W - WIDTH){1'b0}}, x} + {{(RES_W - WIDTH){1'b0}}, y};
    endfunction

    // WIDTH+1 bits hold any difference of two unsigned operands exactly.
    function automatic logic [RES_W-1:0] sub_sext(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic signed [WIDTH:0] d;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        return {{(RES_W - WIDTH){d[WIDTH]}}, d[WIDTH-1:0]};
    endfunction

    assign mul_start = (state == IDLE) && bus.start && !bus.clr &&
                       ((mode_q == MUL) || (mode_q == MAC));

    seq_mul #(
        .WIDTH (WIDTH),
        .RES_W (RES_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (bus.clr),
        .a       (a_q),
        .b       (b_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            mode_q <= ADD;
            state  <= IDLE;
            done_q <= 1'b0;
            ms_q   <= 1'b0;
            mac_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ms_q   <= bus.mode_step;

            // operand loads and mode steps are frozen (not queued) while busy
            if (!mul_busy) begin
                if (bus.ea) a_q <= bus.in_data;
                if (bus.eb) b_q <= bus.in_data;
                if (bus.mode_step && !ms_q)
                    mode_q <= (mode_q == mode_e'(NUM_MODES - 1)) ? ADD
                                                                 : mode_e'(mode_q + 2'd1);
            end

            case (state)
                IDLE: begin
                    if (bus.clr) begin
                        res_q <= '0;
                    end else if (bus.start) begin
                        case (mode_q)
                            ADD: begin
                                res_q  <= add_zext(a_q, b_q);
                                done_q <= 1'b1;
                            end
                            SUB: begin
                                res_q  <= sub_sext(a_q, b_q);
                                done_q <= 1'b1;
                            end
                            default: begin
                                state <= CALC;
                                mac_q <= (mode_q == MAC);
                            end
                        endcase
                    end
                end
                CALC: begin
                    if (bus.clr) begin
                        res_q <= '0;
                        state <= IDLE;
                    end else if (mul_done) begin
                        res_q  <= mac_q ? res_q + mul_prod : mul_prod;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mode    = mode_q;
    assign bus.a_value = a_q;
    assign bus.b_value = b_q;
    assign bus.result  = res_q;
    assign bus.busy    = mul_busy;
    assign bus.done    = done_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the lab datapath. It loads two operands from a shared input bus under separate enables and steps through four operation modes on a mode-step input. Operations are ADD, SUB, MUL and MAC. MUL and MAC use an iterative shift-add multiplier with a start/busy/done handshake. The block sits between the board switch/key conditioning and the display driver; `result` and `mode` feed the 7-segment decoder.

## Interface

Parameters:
- `WIDTH`, default 8: operand width in bits.
- `RES_W`, default 2*WIDTH: result and accumulator width; must be ≥ WIDTH+1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  operand input bus.
- `ea`  in  1  load `in_data` into operand A.
- `eb`  in  1  load `in_data` into operand B.
- `mode_step`  in  1  level input; each rising edge (0→1 between samples) advances `mode`.
- `start`  in  1  begin the operation in the current mode.
- `clr`  in  1  synchronous clear of `result`.
- `mode`  out  2  current mode: 0 ADD, 1 SUB, 2 MUL, 3 MAC.
- `a_value`  out  WIDTH  operand A register.
- `b_value`  out  WIDTH  operand B register.
- `result`  out  RES_W  result register.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse after each `result` write caused by `start`.

## Operation

- Reset (asynchronous, `reset`=0): every output is 0; state IDLE; `mode_step` history register is 0.
- Operand load:
  - `ea`/`eb` load on the clock edge; both may load in the same cycle.
  - Both are ignored while `busy`=1.
- Mode step:
  - Edge detection uses a registered copy of `mode_step`.
  - Mode wraps 3→0.
  - A rising edge seen while `busy`=1 is dropped, not queued.
- FSM states:
  - IDLE:
    - `start` in ADD or SUB writes `result` on that edge; stays IDLE.
    - `start` in MUL or MAC goes to CALC: loads the multiplicand/multiplier copies from A/B, clears the partial product, loads the iteration counter with WIDTH.
  - CALC:
    - Each edge does one shift-add step and decrements the counter.
    - On the edge that completes the WIDTH-th step, `result` is written and the FSM returns to IDLE.
    - `start` is ignored in CALC.
- Arithmetic, all results taken mod 2^RES_W:
  - ADD: zero-extended A+B.
  - SUB: A−B in two's complement, sign-extended to RES_W.
  - MUL: unsigned A*B.
  - MAC: `result` + unsigned A*B, wrapping.
- `clr` priority:
  - `clr` overrides a `start` in the same cycle; the `start` is lost.
  - In CALC, `clr` aborts the operation: FSM returns to IDLE, `result`=0, no `done`.
- Operand timing: `start` together with `ea`/`eb` in the same cycle uses the pre-load A/B values.

## Timing

- Name the `start` edge E0.
- ADD/SUB:
  - `result` is valid after E0.
  - `done`=1 for the cycle between E0 and E1.
- MUL/MAC:
  - `busy`=1 from E0 to E(WIDTH).
  - `result` is written and `busy` falls at E(WIDTH).
  - `done`=1 for the cycle between E(WIDTH) and E(WIDTH+1).
- Back-to-back: a `start` sampled during the `done` cycle is accepted; no dead cycle.
- `mode` changes one edge after the `mode_step` rising edge is sampled.
- Reset mid-CALC: immediate return to IDLE with all outputs 0; no `done`.

## Structure

- Package `alu_seq_pkg`:
  - `mode_e` enum: ADD=0, SUB=1, MUL=2, MAC=3.
  - `NUM_MODES`=4.
  - `state_e` enum: IDLE, CALC.
- Sub-module `seq_mul`:
  - Iterative unsigned shift-add multiplier, parametrised on WIDTH and RES_W.
  - Ports: `clk`, `reset`, `start`, `abort`, `a`, `b`, `busy`, `done`, `product`.
- The top level holds the operand registers, the mode counter and edge detector, the ADD/SUB path, the MAC adder, and the result register.

## Test plan

- Reset, then load A=200, B=100 (WIDTH=8):
  - ADD → `result`=300 with `done` one cycle after `start`.
  - SUB → `result`=16'h0064.
  - Swap to A=100, B=200; SUB → `result`=16'hFF9C.
- MUL with A=255, B=255:
  - `busy` high exactly 8 cycles.
  - `result`=65025 with `done` coincident with `busy` falling.
- MAC with A=B=255, RES_W=16:
  - First pass from `result`=0 gives 65025.
  - A second back-to-back `start` in the `done` cycle gives (2·65025) mod 65536 = 64514.
- Mode stepping:
  - Four `mode_step` pulses from reset → `mode` 1,2,3,0.
  - A pulse during `busy` leaves `mode` unchanged.
  - A held-high `mode_step` advances once.
- Abort and reset during MUL:
  - `clr` at cycle 3 → `busy`=0 and `result`=0 next cycle, no `done`.
  - Asynchronous `reset` mid-CALC → all outputs 0 without waiting for a clock edge.
- Same-cycle `start`+`ea` with `in_data`=7, prior A=3, B=2, mode ADD → `result`=5, and `a_value`=7 afterwards.
